// File: rtl/aec_pkg.sv
// ============================================================================
//  Module      : aec_pkg
//  Description : Shared widths, ASCII constants and transmitter state type
//                for the AEC ASCII expression interface.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package aec_pkg;

    localparam int RES_W   = 7;
    localparam int ASCII_W = 8;

    localparam logic [ASCII_W-1:0] ASCII_EQ    = 8'h3D;
    localparam logic [ASCII_W-1:0] ASCII_PLUS  = 8'h2B;
    localparam logic [ASCII_W-1:0] ASCII_MINUS = 8'h2D;
    localparam logic [ASCII_W-1:0] ASCII_MUL   = 8'h2A;
    localparam logic [ASCII_W-1:0] ASCII_LPAR  = 8'h28;
    localparam logic [ASCII_W-1:0] ASCII_RPAR  = 8'h29;
    localparam logic [ASCII_W-1:0] ASCII_ZERO  = 8'h30;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/aec_byte_fifo.sv
// ============================================================================
//  Module      : aec_byte_fifo
//  Description : Synchronous first-word-fall-through byte FIFO. The head
//                entry is always visible on o_data while o_empty is low.
//  Ports       : i_push/i_data write side, i_pop read side, o_data head,
//                o_full, o_empty, o_count (occupancy, 0..DEPTH).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module aec_byte_fifo #(
    parameter int DEPTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [7:0]                   i_data,
    input  logic                         i_pop,
    output logic [7:0]                   o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH+1);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // A push while full is still accepted when the same cycle pops, since
    // the slot being read frees up at the same edge it is overwritten.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/aec_expr_tx.sv
// ============================================================================
//  Module      : aec_expr_tx
//  Description : AEC expression transmitter. Host fills a byte FIFO and
//                pulses start; the block streams bytes up to and including
//                '=', waits for the AEC result, compares it with the latched
//                expected value and reports pass / fmt_err / timeout.
//  Ports       : wr_en/wr_data/wr_full  host FIFO write side
//                start/expected         launch one expression
//                ready/ascii_out        byte stream to the AEC
//                valid/result           AEC answer
//                busy/done/res_out/pass/fmt_err/timeout  status
//                pass_cnt/fail_cnt      scoreboard (AEC_TX_SCORE_EN only)
//  Options     : define AEC_TX_SCORE_EN to add saturating pass/fail counters.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module aec_expr_tx
    import aec_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int TIMEOUT = 5000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [ASCII_W-1:0] wr_data,
    output logic               wr_full,
    input  logic               start,
    input  logic [RES_W-1:0]   expected,
    output logic               ready,
    output logic [ASCII_W-1:0] ascii_out,
    input  logic               valid,
    input  logic [RES_W-1:0]   result,
    output logic               busy,
    output logic               done,
    output logic [RES_W-1:0]   res_out,
    output logic               pass,
    output logic               fmt_err,
    output logic               timeout
`ifdef AEC_TX_SCORE_EN
    ,
    output logic [7:0]         pass_cnt,
    output logic [7:0]         fail_cnt
`endif
);

    localparam int TW = $clog2(TIMEOUT+1);

    tx_state_t          r_state;
    tx_state_t          w_next;
    logic [ASCII_W-1:0] w_head;
    logic               w_empty;
    logic               w_pop;
    logic               w_accept;
    logic               w_tmo_hit;
    logic               r_sent_eq;     // byte currently on ascii_out is '='
    logic [RES_W-1:0]   r_expected;
    logic [TW-1:0]      r_wait_cnt;

    aec_byte_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (wr_en),
        .i_data  (wr_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (wr_full),
        .o_empty (w_empty),
        .o_count ()
    );

    assign w_accept  = (r_state == ST_IDLE) && start && !w_empty;
    assign w_tmo_hit = (r_wait_cnt == TW'(TIMEOUT - 1));

    // The first byte is popped on the accepting edge so it is presented
    // together with ready in the first SEND cycle.
    assign w_pop = w_accept ||
                   ((r_state == ST_SEND) && !r_sent_eq && !w_empty);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_SEND;
            ST_SEND: begin
                if (r_sent_eq)    w_next = ST_WAIT;
                else if (w_empty) w_next = ST_DONE;
            end
            ST_WAIT: if (valid || w_tmo_hit) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy = (r_state == ST_SEND) || (r_state == ST_WAIT);
        done = (r_state == ST_DONE);
    end

    // Registered stream and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            ascii_out  <= '0;
            ready      <= 1'b0;
            r_sent_eq  <= 1'b0;
            r_expected <= '0;
            res_out    <= '0;
            pass       <= 1'b0;
            fmt_err    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            ascii_out <= '0;
            ready     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        ascii_out  <= w_head;
                        ready      <= 1'b1;
                        r_sent_eq  <= (w_head == ASCII_EQ);
                        r_expected <= expected;
                        pass       <= 1'b0;
                        fmt_err    <= 1'b0;
                        timeout    <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (!r_sent_eq) begin
                        if (w_empty) begin
                            fmt_err <= 1'b1;
                        end else begin
                            ascii_out <= w_head;
                            r_sent_eq <= (w_head == ASCII_EQ);
                        end
                    end
                end
                ST_WAIT: begin
                    if (valid) begin
                        res_out <= result;
                        pass    <= (result == r_expected);
                    end else if (w_tmo_hit) begin
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // WAIT cycle counter, zero on every WAIT entry
    always_ff @(posedge clk) begin
        if (rst || (r_state != ST_WAIT)) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

`ifdef AEC_TX_SCORE_EN
    // pass is already final during DONE, so tally there
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (r_state == ST_DONE) begin
            if (pass) begin
                if (pass_cnt != 8'hFF) pass_cnt <= pass_cnt + 1'b1;
            end else begin
                if (fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_aec_expr_tx.sv
// ============================================================================
//  Module      : tb_aec_expr_tx
//  Description : Directed self-checking bench for aec_expr_tx (DEPTH=8,
//                TIMEOUT=16). Optional counters checked when
//                AEC_TX_SCORE_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_aec_expr_tx;
    import aec_pkg::*;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_en;
    logic [7:0]   wr_data;
    logic         wr_full;
    logic         start;
    logic [6:0]   expected;
    logic         ready;
    logic [7:0]   ascii_out;
    logic         valid;
    logic [6:0]   result;
    logic         busy;
    logic         done;
    logic [6:0]   res_out;
    logic         pass;
    logic         fmt_err;
    logic         timeout;
`ifdef AEC_TX_SCORE_EN
    logic [7:0]   pass_cnt;
    logic [7:0]   fail_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    aec_expr_tx #(
        .DEPTH     (DEPTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_full   (wr_full),
        .start     (start),
        .expected  (expected),
        .ready     (ready),
        .ascii_out (ascii_out),
        .valid     (valid),
        .result    (result),
        .busy      (busy),
        .done      (done),
        .res_out   (res_out),
        .pass      (pass),
        .fmt_err   (fmt_err),
        .timeout   (timeout)
`ifdef AEC_TX_SCORE_EN
        ,
        .pass_cnt  (pass_cnt),
        .fail_cnt  (fail_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_str(input logic [71:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = s[8*(n-1-i) +: 8];
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic start_expr(input logic [6:0] e);
        expected = e;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Checks n bytes on consecutive cycles, ready only with the first.
    task automatic exp_stream(input logic [63:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            chk("stream_byte", 32'(ascii_out), 32'(s[8*(n-1-i) +: 8]));
            chk("stream_ready", 32'(ready), (i == 0) ? 32'd1 : 32'd0);
            chk("stream_busy", 32'(busy), 32'd1);
            tick();
        end
    endtask

    task automatic give_result(input logic [6:0] r, input int delay);
        repeat (delay) tick();
        valid  = 1'b1;
        result = r;
        tick();
        valid  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; start = 1'b0;
        expected = '0; valid = 1'b0; result = '0;
        tick(); tick();
        chk("reset_outputs",
            32'({ready, ascii_out, busy, done, res_out, pass, fmt_err, timeout, wr_full}), 32'd0);
        rst = 1'b0;
        tick();

        // start with empty FIFO is ignored
        start_expr(7'd1);
        chk("empty_start_busy", 32'(busy), 32'd0);
        tick();
        chk("empty_start_ready", 32'(ready), 32'd0);

        // 1: "3+4=" expected 7, result 7
        push_str(72'h332B343D, 4);
        start_expr(7'd7);
        exp_stream(64'h332B343D, 4);
        chk("t1_wait_ascii", 32'(ascii_out), 32'd0);
        chk("t1_wait_busy", 32'(busy), 32'd1);
        give_result(7'd7, 2);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_res", 32'(res_out), 32'd7);
        chk("t1_pass", 32'(pass), 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);
        tick();
        chk("t1_done_pulse", 32'(done), 32'd0);
        chk("t1_pass_held", 32'(pass), 32'd1);

        // 2: expected 9, result 7
        push_str(72'h332B343D, 4);
        start_expr(7'd9);
        chk("t2_pass_cleared", 32'(pass), 32'd0);
        exp_stream(64'h332B343D, 4);
        give_result(7'd7, 1);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_pass", 32'(pass), 32'd0);
        chk("t2_res", 32'(res_out), 32'd7);
        tick();
`ifdef AEC_TX_SCORE_EN
        chk("t2_fail_cnt", 32'(fail_cnt), 32'd1);
        chk("t2_pass_cnt", 32'(pass_cnt), 32'd1);
`endif

        // 3: "1+1=2*3=" sends up to the first '=' only
        push_str(72'h312B313D322A333D, 8);
        start_expr(7'd2);
        exp_stream(64'h312B313D, 4);
        chk("t3_fifo_count", 32'(dut.u_fifo.o_count), 32'd4);
        give_result(7'd2, 0);
        chk("t3a_pass", 32'(pass), 32'd1);
        tick();
        start_expr(7'd6);
        exp_stream(64'h322A333D, 4);
        give_result(7'd6, 0);
        chk("t3b_done", 32'(done), 32'd1);
        chk("t3b_res", 32'(res_out), 32'd6);
        chk("t3b_pass", 32'(pass), 32'd1);
        tick();

        // 4: "5+" only -> fmt_err
        push_str(72'h352B, 2);
        start_expr(7'd0);
        exp_stream(64'h352B, 2);
        chk("t4_ascii", 32'(ascii_out), 32'd0);
        chk("t4_fmt_err", 32'(fmt_err), 32'd1);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_pass", 32'(pass), 32'd0);
        tick();
        chk("t4_fmt_held", 32'(fmt_err), 32'd1);
        chk("t4_done_pulse", 32'(done), 32'd0);

        // 5: no valid -> timeout 16 cycles after WAIT entry
        push_str(72'h332B343D, 4);
        start_expr(7'd7);
        chk("t5_fmt_cleared", 32'(fmt_err), 32'd0);
        exp_stream(64'h332B343D, 4);
        repeat (TIMEOUT - 1) tick();
        chk("t5_not_yet_done", 32'(done), 32'd0);
        chk("t5_still_busy", 32'(busy), 32'd1);
        tick();
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_timeout", 32'(timeout), 32'd1);
        chk("t5_pass", 32'(pass), 32'd0);
        tick();

        // 5b: valid on the timeout cycle wins
        push_str(72'h332B343D, 4);
        start_expr(7'd7);
        chk("t5b_tmo_cleared", 32'(timeout), 32'd0);
        exp_stream(64'h332B343D, 4);
        give_result(7'd7, TIMEOUT - 1);
        chk("t5b_done", 32'(done), 32'd1);
        chk("t5b_timeout", 32'(timeout), 32'd0);
        chk("t5b_pass", 32'(pass), 32'd1);
        tick();
`ifdef AEC_TX_SCORE_EN
        chk("t5b_pass_cnt", 32'(pass_cnt), 32'd4);
        chk("t5b_fail_cnt", 32'(fail_cnt), 32'd3);
`endif

        // 6: overfill, then reset mid-SEND
        push_str(72'h3132333435363738, 8);
        chk("t6_full", 32'(wr_full), 32'd1);
        push_str(72'h39, 1);
        chk("t6_dropped", 32'(dut.u_fifo.o_count), 32'(DEPTH));
        start_expr(7'd0);
        chk("t6_first", 32'(ascii_out), 32'h31);
        chk("t6_first_ready", 32'(ready), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_ready", 32'(ready), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_full", 32'(wr_full), 32'd0);
        chk("t6_rst_ascii", 32'(ascii_out), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("t6_no_done", 32'(done), 32'd0);
            tick();
        end
`ifdef AEC_TX_SCORE_EN
        chk("t6_cnt_cleared", 32'({pass_cnt, fail_cnt}), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aec_expr_tx.md
Name: aec_expr_tx

Overview:
Hardware transmitter for the AEC ASCII expression interface; it is the driving end of the protocol the AEC receives.
- Host pushes expression bytes into an internal FIFO, then pulses start.
- Block streams one byte per cycle to the AEC, asserting ready with the first byte, and stops after the '=' byte.
- It then waits for the AEC valid/result, compares the result against an expected value, and reports the outcome.
- Sits between a host/BIST controller and the AEC core; serves as on-chip self-test and as a reusable bench driver.

Parameters:
DEPTH  32  FIFO depth in bytes (power of 2, >=4)
TIMEOUT  5000  max cycles in WAIT before aborting

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wr_en  in  1  push wr_data into FIFO
wr_data  in  8  ASCII byte
wr_full  out  1  FIFO full; wr_en ignored while high
start  in  1  begin one expression; honoured only in IDLE with FIFO non-empty
expected  in  7  expected result, latched on accepted start
ready  out  1  high for exactly the first-byte cycle of an expression
ascii_out  out  8  byte to AEC
valid  in  1  AEC result valid
result  in  7  AEC result
busy  out  1  high in SEND and WAIT
done  out  1  one-cycle pulse at end of each expression
res_out  out  7  captured result, held until next done
pass  out  1  result==expected, valid with done, held
fmt_err  out  1  FIFO emptied before '=', held
timeout  out  1  WAIT exceeded TIMEOUT, held

Behaviour:
- Reset (clk, rst: synchronous, active-high): FIFO emptied; state IDLE.
  - All outputs are 0: ready, ascii_out, busy, done, res_out, pass, fmt_err, timeout. wr_full is 0.
- States: IDLE, SEND, WAIT, DONE.
- IDLE:
  - ascii_out=0, ready=0.
  - Accepted start at cycle t latches expected, clears pass/fmt_err/timeout, and moves to SEND.
  - start with an empty FIFO is ignored.
- SEND (outputs registered):
  - First byte on ascii_out with ready=1 at t+1; byte k at t+1+k with ready=0.
  - One FIFO pop per cycle; the FIFO is first-word-fall-through.
  - After popping 0x3D ('='), go to WAIT; the '=' byte is shown on ascii_out for its cycle.
  - If the FIFO is empty when a pop is needed: ascii_out=0, fmt_err=1, go to DONE.
- WAIT:
  - ascii_out=0. A cycle counter starts at 0 on entry.
  - valid=1 captures result into res_out, sets pass=(result==expected), and goes to DONE.
  - Counter reaching TIMEOUT sets timeout=1, pass=0, and goes to DONE.
  - valid in the same cycle as the timeout wins; timeout is not set.
  - valid outside WAIT is ignored.
- DONE: done=1 for one cycle, then IDLE. start in DONE is ignored.
- FIFO behaviour:
  - Simultaneous push and pop is allowed, including when full; the count is unchanged.
  - Push while full with no pop: byte dropped.
  - Bytes after '=' remain in the FIFO for the next start.
- Reset mid-operation: next cycle IDLE, FIFO empty, ready/busy=0, no done pulse.

Optional Feature:
AEC_TX_SCORE_EN
- Defined: adds outputs pass_cnt[7:0] and fail_cnt[7:0].
  - Each DONE increments pass_cnt if pass, else fail_cnt; fmt_err and timeout count as fail.
  - Counters saturate at 255 and are cleared by rst.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package aec_pkg:
  - RES_W=7 and ASCII_W=8.
  - ASCII constants ASCII_EQ=8'h3D, ASCII_PLUS, ASCII_MINUS, ASCII_MUL, ASCII_LPAR, ASCII_RPAR, ASCII_ZERO.
  - State enum typedef tx_state_t.
- Sub-module aec_byte_fifo:
  - Synchronous first-word-fall-through FIFO, parameterised on DEPTH.
  - Ports: push/pop/data/full/empty/count; count is $clog2(DEPTH+1) bits.

Test Plan:
1. Push 0x33,0x2B,0x34,0x3D ("3+4="), expected=7, start at t.
   - ascii_out=0x33 with ready=1 at t+1; 0x2B, 0x34, 0x3D at t+2..t+4 with ready=0; busy high.
   - Model returns valid with result=7 three cycles later: done pulse, res_out=7, pass=1.
2. Same stream, expected=9, model returns 7 -> done, pass=0, res_out=7; with macro defined, fail_cnt=1.
3. Push "1+1=2*3=" (8 bytes), start -> exactly 4 bytes sent, FIFO count=4. Second start sends 0x32,0x2A,0x33,0x3D with ready on 0x32.
4. Push "5+" only, start -> 0x35, 0x2B sent, then fmt_err=1 and a done pulse; ascii_out=0.
5. TIMEOUT=16, valid never asserted -> timeout=1 and done pulse 16 cycles after WAIT entry, pass=0.
6. Push DEPTH+1 bytes -> wr_full high after DEPTH, last byte dropped. Start, then rst mid-SEND -> next cycle ready=0, busy=0, wr_full=0, no done pulse.
